// File: rtl/ic_req_arbiter_pkg.sv
// Shared bus defaults and width helpers for the interconnect request arbiter.
package ic_req_arbiter_pkg;

    localparam int IC_AW_DEF = 32;
    localparam int IC_DW_DEF = 32;

    function automatic int ic_strb_w(input int dw);
        return dw / 8;
    endfunction

    function automatic int ic_id_w(input int nm);
        return (nm > 1) ? $clog2(nm) : 1;
    endfunction

endpackage

// File: rtl/ic_id_fifo.sv
// In-order FIFO of master IDs for accepted requests awaiting a target response.
module ic_id_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic             g_clk,
    input  logic             g_reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head_data
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full      = (count == FULL_CNT);
    assign empty     = (count == '0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_data = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge g_clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/ic_req_arbiter.sv
// Round-robin arbiter sharing one target port among NM masters, with grant lock
// during target stalls and in-order routing of responses back to the issuer.
module ic_req_arbiter
    import ic_req_arbiter_pkg::*;
#(
    parameter int NM      = 2,
    parameter int AW      = IC_AW_DEF,
    parameter int DW      = IC_DW_DEF,
    parameter int MAX_OUT = 4
) (
    input  logic                   g_clk,
    input  logic                   g_reset,
    input  logic [NM-1:0]          m_req,
    output logic [NM-1:0]          m_gnt,
    input  logic [NM-1:0]          m_wen,
    input  logic [NM*(DW/8)-1:0]   m_strb,
    input  logic [NM*AW-1:0]       m_addr,
    input  logic [NM*DW-1:0]       m_wdata,
    output logic [NM-1:0]          m_recv,
    input  logic [NM-1:0]          m_ack,
    output logic [NM-1:0]          m_error,
    output logic [DW-1:0]          m_rdata,
    output logic                   s_req,
    input  logic                   s_gnt,
    output logic                   s_wen,
    output logic [DW/8-1:0]        s_strb,
    output logic [AW-1:0]          s_addr,
    output logic [DW-1:0]          s_wdata,
    input  logic                   s_recv,
    output logic                   s_ack,
    input  logic                   s_error,
    input  logic [DW-1:0]          s_rdata,
    output logic                   orphan_rsp
);

    localparam int SW = ic_strb_w(DW);
    localparam int IW = ic_id_w(NM);

    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] lock_id;
    logic [IW-1:0] winner;
    logic [IW-1:0] head_id;
    logic          lock;
    logic          has_winner;
    logic          fifo_full;
    logic          fifo_empty;
    logic          accept;
    logic          stall;
    logic          pop;

    // Scan downward so the candidate closest to rr_ptr is the last one written.
    always_comb begin
        int cand;
        cand       = 0;
        winner     = lock_id;
        has_winner = lock;
        for (int k = NM - 1; k >= 0; k--) begin
            cand = (int'(rr_ptr) + k) % NM;
            if (!lock && m_req[cand]) begin
                winner     = IW'(cand);
                has_winner = 1'b1;
            end
        end
    end

    assign s_req  = has_winner && m_req[winner] && !fifo_full;
    assign accept = s_req && s_gnt;
    assign stall  = s_req && !s_gnt;

    always_comb begin
        s_wen   = 1'b0;
        s_strb  = '0;
        s_addr  = '0;
        s_wdata = '0;
        m_gnt   = '0;
        if (has_winner) begin
            s_wen         = m_wen[winner];
            s_strb        = m_strb[winner*SW +: SW];
            s_addr        = m_addr[winner*AW +: AW];
            s_wdata       = m_wdata[winner*DW +: DW];
            m_gnt[winner] = accept;
        end
    end

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            rr_ptr     <= '0;
            lock       <= 1'b0;
            lock_id    <= '0;
            orphan_rsp <= 1'b0;
        end else begin
            if (accept) begin
                rr_ptr <= (int'(winner) == NM - 1) ? '0 : winner + 1'b1;
                lock   <= 1'b0;
            end else if (stall) begin
                lock    <= 1'b1;
                lock_id <= winner;
            end
            if (s_recv && fifo_empty) orphan_rsp <= 1'b1;
        end
    end

    // With nothing outstanding, stray responses are drained rather than stalled.
    always_comb begin
        m_recv  = '0;
        m_error = '0;
        s_ack   = s_recv;
        if (!fifo_empty) begin
            m_recv[head_id]  = s_recv;
            m_error[head_id] = s_error;
            s_ack            = m_ack[head_id];
        end
    end

    assign pop     = s_recv && s_ack && !fifo_empty;
    assign m_rdata = s_rdata;

    ic_id_fifo #(
        .WIDTH (IW),
        .DEPTH (MAX_OUT)
    ) u_id_fifo (
        .g_clk     (g_clk),
        .g_reset   (g_reset),
        .push      (accept),
        .push_data (winner),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head_data (head_id)
    );

endmodule
